// File: rtl/wbk_param.sv
// Parametrised object write-back: advances data pointer / height / scale remainder.
// Optional macro WBK_STEP2_EN: the scaled loop performs up to two iterations per cycle.
module wbk_param #(
    parameter int DATA_W   = 21,
    parameter int HEIGHT_W = 10,
    parameter int DWIDTH_W = 10,
    parameter int SCALE_W  = 8,
    parameter int FRAC_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wbkstart,
    input  logic                scaled,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [HEIGHT_W-1:0] height_in,
    input  logic [SCALE_W-1:0]  rem_in,
    input  logic [DWIDTH_W-1:0] dwidth,
    input  logic [SCALE_W-1:0]  vscale,
    output logic [DATA_W-1:0]   newdata,
    output logic [HEIGHT_W-1:0] newheight,
    output logic [SCALE_W-1:0]  newrem,
    output logic                heightnz,
    output logic                busy,
    output logic                wbkdone
);
    typedef enum logic [1:0] {S_IDLE, S_STEP, S_LOOP, S_DONE} state_t;

    localparam logic signed [SCALE_W:0] ONE_LINE = (SCALE_W+1)'(1 << FRAC_W);

    state_t                    r_state, w_next;
    logic [DATA_W-1:0]         r_d, w_d, w_d1, w_d2, w_dl;
    logic [HEIGHT_W-1:0]       r_h, w_h, w_h1, w_h2, w_hl;
    logic signed [SCALE_W:0]   r_r, w_r, w_r1, w_r2, w_rl;
    logic                      w_stop1, w_stop2, w_stopl;
    logic [DATA_W-1:0]         r_pitch;
    logic [SCALE_W-1:0]        r_vs;
    logic                      r_scaled;
    logic [DATA_W-1:0]         r_newdata;
    logic [HEIGHT_W-1:0]       r_newheight;
    logic [SCALE_W-1:0]        r_newrem;

    // One source-line iteration; height exhaustion stops without touching R.
    always_comb begin
        w_d1    = r_d;
        w_h1    = r_h;
        w_r1    = r_r;
        w_stop1 = 1'b1;
        if (r_h != '0) begin
            w_r1    = r_r + $signed({1'b0, r_vs});
            w_d1    = r_d + r_pitch;
            w_h1    = r_h - 1'b1;
            w_stop1 = !w_r1[SCALE_W] || (w_h1 == '0);
        end
        // Second iteration only runs when the first left R < 0 and H != 0.
        w_d2    = w_d1 + r_pitch;
        w_h2    = w_h1 - 1'b1;
        w_r2    = w_r1 + $signed({1'b0, r_vs});
        w_stop2 = !w_r2[SCALE_W] || (w_h2 == '0);
`ifdef WBK_STEP2_EN
        w_dl    = w_stop1 ? w_d1 : w_d2;
        w_hl    = w_stop1 ? w_h1 : w_h2;
        w_rl    = w_stop1 ? w_r1 : w_r2;
        w_stopl = w_stop1 || w_stop2;
`else
        w_dl    = w_d1;
        w_hl    = w_h1;
        w_rl    = w_r1;
        w_stopl = w_stop1;
`endif
    end

    always_comb begin
        w_next = r_state;
        w_d    = r_d;
        w_h    = r_h;
        w_r    = r_r;
        case (r_state)
            S_IDLE: if (wbkstart) begin
                w_next = S_STEP;
                w_d    = data_in;
                w_h    = height_in;
                w_r    = $signed({1'b0, rem_in});
            end
            S_STEP: if (!r_scaled) begin
                w_d    = r_d + r_pitch;
                w_h    = (r_h != '0) ? r_h - 1'b1 : r_h;
                w_next = S_DONE;
            end else begin
                w_r    = r_r - ONE_LINE;
                w_next = w_r[SCALE_W] ? S_LOOP : S_DONE;
            end
            S_LOOP: begin
                w_d    = w_dl;
                w_h    = w_hl;
                w_r    = w_rl;
                w_next = w_stopl ? S_DONE : S_LOOP;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_d         <= '0;
            r_h         <= '0;
            r_r         <= '0;
            r_pitch     <= '0;
            r_vs        <= '0;
            r_scaled    <= 1'b0;
            r_newdata   <= '0;
            r_newheight <= '0;
            r_newrem    <= '0;
        end else begin
            r_state <= w_next;
            r_d     <= w_d;
            r_h     <= w_h;
            r_r     <= w_r;
            if (r_state == S_IDLE && wbkstart) begin
                r_pitch  <= DATA_W'(dwidth);
                r_vs     <= vscale;
                r_scaled <= scaled;
            end
            // Results land together with the DONE state so they are valid with wbkdone.
            if (w_next == S_DONE) begin
                r_newdata   <= w_d;
                r_newheight <= w_h;
                r_newrem    <= w_r[SCALE_W-1:0];
            end
        end
    end

    assign newdata   = r_newdata;
    assign newheight = r_newheight;
    assign newrem    = r_newrem;
    assign heightnz  = (r_newheight != '0);
    assign busy      = (r_state != S_IDLE);
    assign wbkdone   = (r_state == S_DONE);
endmodule

// File: tb/tb_wbk_param.sv
// Randomized + directed bench for wbk_param against a loop-level arithmetic model.
module tb_wbk_param;
    localparam int DATA_W = 21, HEIGHT_W = 10, DWIDTH_W = 10, SCALE_W = 8, FRAC_W = 5;
    localparam int DMASK = (1 << DATA_W) - 1;

    logic clk = 0, reset = 1, wbkstart = 0, scaled = 0;
    logic [DATA_W-1:0]   data_in = '0;
    logic [HEIGHT_W-1:0] height_in = '0;
    logic [SCALE_W-1:0]  rem_in = '0, vscale = '0;
    logic [DWIDTH_W-1:0] dwidth = '0;
    logic [DATA_W-1:0]   newdata;
    logic [HEIGHT_W-1:0] newheight;
    logic [SCALE_W-1:0]  newrem;
    logic heightnz, busy, wbkdone;

    int tests = 0, fails = 0;

    wbk_param #(.DATA_W(DATA_W), .HEIGHT_W(HEIGHT_W), .DWIDTH_W(DWIDTH_W),
                .SCALE_W(SCALE_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .reset(reset), .wbkstart(wbkstart), .scaled(scaled),
        .data_in(data_in), .height_in(height_in), .rem_in(rem_in), .dwidth(dwidth),
        .vscale(vscale), .newdata(newdata), .newheight(newheight), .newrem(newrem),
        .heightnz(heightnz), .busy(busy), .wbkdone(wbkdone));

    always #5 clk = ~clk;

    typedef struct { int d; int h; int r; int lat; } exp_t;

    // Walks output lines one at a time until a source line is crossed.
    function automatic exp_t model(bit sc, int d, int h, int r, int dw, int vs);
        exp_t e;
        int n = 0;
        e.lat = 2;
        if (!sc) begin
            d = (d + dw) & DMASK;
            if (h != 0) h = h - 1;
        end else begin
            r = r - (1 << FRAC_W);
            if (r < 0) begin
                while (1) begin
                    n++;
                    if (h == 0) break;
                    r = r + vs;
                    d = (d + dw) & DMASK;
                    h = h - 1;
                    if (r >= 0 || h == 0) break;
                end
            end
`ifdef WBK_STEP2_EN
            e.lat = 2 + (n + 1) / 2;
`else
            e.lat = 2 + n;
`endif
        end
        e.d = d; e.h = h; e.r = r & ((1 << SCALE_W) - 1);
        return e;
    endfunction

    // Drives one start and waits (bounded) for wbkdone; lat = -1 on timeout.
    task automatic run_op(input bit sc, input int d, input int h, input int r, input int dw,
                          input int vs, output int lat);
        @(negedge clk);
        scaled = sc; data_in = d; height_in = h; rem_in = r; dwidth = dw; vscale = vs;
        wbkstart = 1;
        @(negedge clk);
        wbkstart = 0;
        // Scramble operands to prove they were captured at start.
        data_in = $urandom; height_in = $urandom; rem_in = $urandom;
        dwidth = $urandom; vscale = $urandom; scaled = $urandom;
        lat = -1;
        for (int k = 1; k <= 1200; k++) begin
            if (wbkdone) begin lat = k; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++;
        if ({newdata, newheight, newrem, heightnz, busy, wbkdone} !== '0) begin
            fails++;
            $display("FAIL reset: got d=%h h=%h r=%h nz=%b busy=%b done=%b, want all 0",
                     newdata, newheight, newrem, heightnz, busy, wbkdone);
        end
        reset = 0;
    endtask

    task automatic check_op(input string name, input bit sc, input int d, input int h,
                            input int r, input int dw, input int vs);
        exp_t e;
        int lat;
        e = model(sc, d, h, r, dw, vs);
        run_op(sc, d, h, r, dw, vs, lat);
        tests++;
        if (lat !== e.lat || newdata !== DATA_W'(e.d) || newheight !== HEIGHT_W'(e.h) ||
            newrem !== SCALE_W'(e.r) || heightnz !== (e.h != 0) || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s: got lat=%0d d=%h h=%0d r=%h nz=%b busy=%b, want lat=%0d d=%h h=%0d r=%h nz=%b busy=1",
                     name, lat, newdata, newheight, newrem, heightnz, busy,
                     e.lat, e.d, e.h, e.r, e.h != 0);
        end
    endtask

    task automatic test_directed;
        check_op("unscaled",      0, 'h100, 5, 'h33, 'h28, 0);
        check_op("unscaled_h0",   0, 'h100, 0, 'h12, 'h28, 7);
        check_op("scaled_nocross",1, 'h200, 3, 'h40, 'h10, 'h20);
        check_op("scaled_multi",  1, 0, 10, 'h10, 4, 'h08);
        check_op("vscale0",       1, 'h50, 3, 0, 6, 0);
        check_op("data_wrap",     0, 'h1FFFFF, 2, 0, 1, 0);
        check_op("scaled_h0",     1, 'h77, 0, 3, 9, 'h40);
        check_op("rem_max",       1, 'h1, 7, 'hFF, 'h3FF, 'hFF);
    endtask

    task automatic test_random;
        for (int i = 0; i < 150; i++)
            check_op("random", 1'($urandom), $urandom & DMASK,
                     ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 40),
                     $urandom_range(0, 255), $urandom_range(0, 1023),
                     ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255));
    endtask

    // Start pulsed in the DONE cycle must be ignored; the next cycle's start is accepted.
    task automatic test_back_to_back;
        int seen = 0;
        check_op("b2b_first", 0, 'h10, 2, 0, 1, 0);
        scaled = 0; data_in = 'h999; height_in = 9; dwidth = 1; wbkstart = 1;
        @(negedge clk);
        wbkstart = 0;
        for (int k = 0; k < 6; k++) begin
            if (busy || wbkdone) seen++;
            @(negedge clk);
        end
        tests++;
        if (seen !== 0 || newdata !== DATA_W'('h11)) begin
            fails++;
            $display("FAIL start_in_done: got activity=%0d d=%h, want 0 and d=11", seen, newdata);
        end
        check_op("b2b_a", 1, 'h40, 4, 0, 2, 'h10);
        check_op("b2b_b", 0, 'h40, 4, 0, 2, 'h10);
    endtask

    task automatic test_busy_ignore;
        int dones = 0;
        @(negedge clk);
        scaled = 1; data_in = 'h100; height_in = 6; rem_in = 0; dwidth = 3; vscale = 0;
        wbkstart = 1;
        @(negedge clk);
        data_in = 'h5; height_in = 1; scaled = 0;
        for (int k = 1; k < 25; k++) begin
            wbkstart = (k < 4);
            if (wbkdone) dones++;
            @(negedge clk);
        end
        wbkstart = 0;
        tests++;
        if (dones !== 1 || newdata !== DATA_W'('h112) || newheight !== 0 || newrem !== 8'hE0) begin
            fails++;
            $display("FAIL busy_ignore: got dones=%0d d=%h h=%0d r=%h, want 1 112 0 e0",
                     dones, newdata, newheight, newrem);
        end
    endtask

    task automatic test_reset_midloop;
        int dones = 0;
        @(negedge clk);
        scaled = 1; data_in = 'h300; height_in = 20; rem_in = 0; dwidth = 1; vscale = 0;
        wbkstart = 1;
        @(negedge clk);
        wbkstart = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        tests++;
        if ({newdata, newheight, newrem, heightnz, busy, wbkdone} !== '0) begin
            fails++;
            $display("FAIL reset_midloop: got d=%h h=%h r=%h nz=%b busy=%b done=%b, want all 0",
                     newdata, newheight, newrem, heightnz, busy, wbkdone);
        end
        reset = 0;
        for (int k = 0; k < 30; k++) begin
            if (wbkdone || busy) dones++;
            @(negedge clk);
        end
        tests++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL reset_abandon: got %0d active cycles, want 0", dones);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_busy_ignore;
        test_reset_midloop;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
